// File: rtl/l2_resp_demux2.sv
// Routes in-order L2 responses back to CH0/CH1 using a grant-order tag FIFO; 1-cycle registered latency.
// No response backpressure; gnt_block_o throttles the request mux when MAX_OUTSTANDING tags are in flight.
module l2_resp_demux2 #(
    parameter  int ID_WIDTH        = 20,
    parameter  int DATA_WIDTH      = 64,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  gnt_CH0_i,
    input  logic                  gnt_CH1_i,
    input  logic                  r_valid_i,
    input  logic [DATA_WIDTH-1:0] r_rdata_i,
    input  logic [ID_WIDTH-1:0]   r_ID_i,
    output logic                  r_valid_CH0_o,
    output logic [DATA_WIDTH-1:0] r_rdata_CH0_o,
    output logic [ID_WIDTH-1:0]   r_ID_CH0_o,
    output logic                  r_valid_CH1_o,
    output logic [DATA_WIDTH-1:0] r_rdata_CH1_o,
    output logic [ID_WIDTH-1:0]   r_ID_CH1_o,
    output logic                  gnt_block_o,
    output logic [CNT_WIDTH-1:0]  outstanding_o,
    output logic [2:0]            err_o
);

    localparam int PTR_WIDTH = $clog2(MAX_OUTSTANDING);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
    } resp_t;

    logic [MAX_OUTSTANDING-1:0] tag_mem;
    logic [PTR_WIDTH-1:0]       wr_ptr, rd_ptr;
    logic [CNT_WIDTH-1:0]       count;
    resp_t                      resp_ch0, resp_ch1;
    logic                       vld_ch0, vld_ch1;
    logic [2:0]                 err_q;

    logic grant_any, fifo_full, fifo_empty;
    logic push, pop, push_tag, head_tag;
    logic overflow, unexpected, dual_gnt;

    assign grant_any  = gnt_CH0_i | gnt_CH1_i;
    assign fifo_full  = (count == CNT_WIDTH'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign pop        = r_valid_i & ~fifo_empty;
    // A pop frees a slot this cycle, so a grant while full is still accepted.
    assign push       = grant_any & (~fifo_full | pop);
    assign push_tag   = gnt_CH1_i & ~gnt_CH0_i;
    assign head_tag   = tag_mem[rd_ptr];

    assign overflow   = grant_any & fifo_full & ~pop;
    assign unexpected = r_valid_i & fifo_empty;
    assign dual_gnt   = gnt_CH0_i & gnt_CH1_i;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= push_tag;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Only the selected channel's payload is updated; the other holds its last response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_ch0  <= 1'b0;
            vld_ch1  <= 1'b0;
            resp_ch0 <= '0;
            resp_ch1 <= '0;
        end else begin
            vld_ch0 <= pop & ~head_tag;
            vld_ch1 <= pop & head_tag;
            if (pop && !head_tag) begin
                resp_ch0 <= '{id: r_ID_i, data: r_rdata_i};
            end
            if (pop && head_tag) begin
                resp_ch1 <= '{id: r_ID_i, data: r_rdata_i};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_q | {dual_gnt, unexpected, overflow};
        end
    end

    assign r_valid_CH0_o = vld_ch0;
    assign r_rdata_CH0_o = resp_ch0.data;
    assign r_ID_CH0_o    = resp_ch0.id;
    assign r_valid_CH1_o = vld_ch1;
    assign r_rdata_CH1_o = resp_ch1.data;
    assign r_ID_CH1_o    = resp_ch1.id;
    assign gnt_block_o   = fifo_full;
    assign outstanding_o = count;
    assign err_o         = err_q;

endmodule

// File: tb/tb_l2_resp_demux2.sv
// Table-driven bench for l2_resp_demux2 with a tag-queue scoreboard for response routing.
module tb_l2_resp_demux2;

    localparam int IDW = 20;
    localparam int DW  = 64;
    localparam int MAXO = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           gnt_CH0_i = 1'b0, gnt_CH1_i = 1'b0, r_valid_i = 1'b0;
    logic [DW-1:0]  r_rdata_i = '0;
    logic [IDW-1:0] r_ID_i = '0;
    logic           r_valid_CH0_o, r_valid_CH1_o;
    logic [DW-1:0]  r_rdata_CH0_o, r_rdata_CH1_o;
    logic [IDW-1:0] r_ID_CH0_o, r_ID_CH1_o;
    logic           gnt_block_o;
    logic [2:0]     outstanding_o;
    logic [2:0]     err_o;

    l2_resp_demux2 #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n),
        .gnt_CH0_i(gnt_CH0_i), .gnt_CH1_i(gnt_CH1_i),
        .r_valid_i(r_valid_i), .r_rdata_i(r_rdata_i), .r_ID_i(r_ID_i),
        .r_valid_CH0_o(r_valid_CH0_o), .r_rdata_CH0_o(r_rdata_CH0_o), .r_ID_CH0_o(r_ID_CH0_o),
        .r_valid_CH1_o(r_valid_CH1_o), .r_rdata_CH1_o(r_rdata_CH1_o), .r_ID_CH1_o(r_ID_CH1_o),
        .gnt_block_o(gnt_block_o), .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit             rst;
        bit             g0, g1, rv;
        logic [DW-1:0]  d;
        logic [IDW-1:0] id;
        int             out;
        logic [2:0]     err;
    } vec_t;

    typedef struct {
        bit             ch;
        logic [DW-1:0]  d;
        logic [IDW-1:0] id;
    } exp_t;

    vec_t  vecs[$];
    bit    tagq[$];
    exp_t  expq[$];
    logic [DW-1:0]  hold_d[2];
    logic [IDW-1:0] hold_id[2];
    int total = 0;
    int bad   = 0;

    function automatic void add(bit rst, bit g0, bit g1, bit rv, logic [DW-1:0] d,
                                logic [IDW-1:0] id, int out, logic [2:0] err);
        vec_t v;
        v.rst = rst; v.g0 = g0; v.g1 = g1; v.rv = rv;
        v.d = d; v.id = id; v.out = out; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int step, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, step, act, exp);
        end
    endtask

    task automatic do_reset(input int step);
        @(negedge clk);
        gnt_CH0_i = 0; gnt_CH1_i = 0; r_valid_i = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_vld0", step, DW'(r_valid_CH0_o), 0);
        chk("rst_vld1", step, DW'(r_valid_CH1_o), 0);
        chk("rst_data", step, r_rdata_CH0_o | r_rdata_CH1_o, 0);
        chk("rst_id", step, DW'(r_ID_CH0_o | r_ID_CH1_o), 0);
        chk("rst_out", step, DW'(outstanding_o), 0);
        chk("rst_blk", step, DW'(gnt_block_o), 0);
        chk("rst_err", step, DW'(err_o), 0);
        tagq.delete();
        expq.delete();
        for (int c = 0; c < 2; c++) begin
            hold_d[c] = '0;
            hold_id[c] = '0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int step, input vec_t v);
        int sz;
        bit pop, push, t;
        exp_t e;
        logic ev0, ev1;
        if (v.rst) do_reset(step);
        gnt_CH0_i = v.g0; gnt_CH1_i = v.g1; r_valid_i = v.rv;
        r_rdata_i = v.d; r_ID_i = v.id;
        sz   = tagq.size();
        pop  = v.rv && sz != 0;
        push = (v.g0 || v.g1) && (sz < MAXO || pop);
        if (pop) begin
            t = tagq.pop_front();
            e.ch = t; e.d = v.d; e.id = v.id;
            expq.push_back(e);
        end
        if (push) tagq.push_back(v.g1 & ~v.g0);
        @(posedge clk);
        #1;
        gnt_CH0_i = 0; gnt_CH1_i = 0; r_valid_i = 0;
        ev0 = 0; ev1 = 0;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            if (e.ch) ev1 = 1; else ev0 = 1;
            hold_d[e.ch]  = e.d;
            hold_id[e.ch] = e.id;
        end
        chk("vld_ch0", step, DW'(r_valid_CH0_o), DW'(ev0));
        chk("vld_ch1", step, DW'(r_valid_CH1_o), DW'(ev1));
        chk("rdata_ch0", step, r_rdata_CH0_o, hold_d[0]);
        chk("rdata_ch1", step, r_rdata_CH1_o, hold_d[1]);
        chk("id_ch0", step, DW'(r_ID_CH0_o), DW'(hold_id[0]));
        chk("id_ch1", step, DW'(r_ID_CH1_o), DW'(hold_id[1]));
        chk("outstanding", step, DW'(outstanding_o), DW'(v.out));
        chk("gnt_block", step, DW'(gnt_block_o), DW'(v.out == MAXO));
        chk("err", step, DW'(err_o), DW'(v.err));
    endtask

    initial begin
        // in-order routing, latency 1
        add(1, 1, 0, 0, 0,    0, 1, 3'b000);
        add(0, 0, 1, 0, 0,    0, 2, 3'b000);
        add(0, 0, 1, 1, 'hA,  1, 2, 3'b000);
        add(0, 0, 0, 1, 'hB,  2, 1, 3'b000);
        add(0, 0, 0, 1, 'hC,  3, 0, 3'b000);
        add(0, 0, 0, 0, 0,    0, 0, 3'b000);
        // fill, overflow, drain
        for (int i = 1; i <= 4; i++) add(0, 1, 0, 0, 0, 0, i, 3'b000);
        add(0, 1, 0, 0, 0, 0, 4, 3'b001);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 1, DW'('h10 + i), IDW'(10 + i), 3 - i, 3'b001);
        // full with simultaneous grant and response
        add(1, 1, 0, 0, 0, 0, 1, 3'b000);
        for (int i = 2; i <= 4; i++) add(0, 1, 0, 0, 0, 0, i, 3'b000);
        add(0, 0, 1, 1, 'hD0, 20, 4, 3'b000);
        for (int i = 1; i <= 4; i++) add(0, 0, 0, 1, DW'('hD0 + i), IDW'(20 + i), 4 - i, 3'b000);
        // unexpected response, then normal traffic
        add(0, 0, 0, 1, 'hDEAD, 7, 0, 3'b010);
        add(0, 1, 0, 0, 0,      0, 1, 3'b010);
        add(0, 0, 0, 1, 'h55,   5, 0, 3'b010);
        // dual grant resolves to CH0
        add(0, 1, 1, 0, 0,    0, 1, 3'b110);
        add(0, 0, 0, 1, 'h66, 6, 0, 3'b110);
        // alternating traffic across pointer wrap, reset with two in flight
        add(1, 1, 0, 0, 0, 0, 1, 3'b000);
        add(0, 0, 1, 0, 0, 0, 2, 3'b000);
        for (int k = 0; k < 8; k++)
            add(0, (k % 2) == 0, (k % 2) == 1, 1, DW'('h100 + k), IDW'(40 + k), 2, 3'b000);
        add(1, 0, 0, 1, 'h77, 9, 0, 3'b010);

        for (int s = 0; s < vecs.size(); s++) apply(s, vecs[s]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l2_resp_demux2.md
Name: l2_resp_demux2

Overview:
- Response-side companion of the 2:1 round-robin L2 request mux.
- Records, in grant order, which of two initiator channels (CH0/CH1) each granted L2 request came from.
- Routes each in-order L2 response (read data, ID) back to the originating channel with one cycle of registered latency.
- Provides a grant-block output so the request side never exceeds the outstanding-transaction capacity, and sticky protocol-error flags.

Parameters:
ID_WIDTH, 20, width of the transaction ID returned with each response
DATA_WIDTH, 64, width of response read data
MAX_OUTSTANDING, 4, depth of the routing-tag FIFO; power of two, >= 2
CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), width of outstanding_o (derived, not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
gnt_CH0_i  input  1  CH0 request granted by L2 this cycle
gnt_CH1_i  input  1  CH1 request granted by L2 this cycle
r_valid_i  input  1  L2 response valid (one per granted request, in order, no backpressure)
r_rdata_i  input  DATA_WIDTH  L2 response data
r_ID_i  input  ID_WIDTH  L2 response ID
r_valid_CH0_o  output  1  response valid to CH0
r_rdata_CH0_o  output  DATA_WIDTH  response data to CH0
r_ID_CH0_o  output  ID_WIDTH  response ID to CH0
r_valid_CH1_o  output  1  response valid to CH1
r_rdata_CH1_o  output  DATA_WIDTH  response data to CH1
r_ID_CH1_o  output  ID_WIDTH  response ID to CH1
gnt_block_o  output  1  tag FIFO full; request mux must AND ~gnt_block_o into data_gnt_i
outstanding_o  output  CNT_WIDTH  current tag FIFO occupancy
err_o  output  3  sticky errors: [0] overflow, [1] unexpected response, [2] dual grant

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0: valids, rdata, ID, err_o, outstanding_o, gnt_block_o.
  - Read/write pointers and count cleared.
  - In-flight tags are discarded; a response arriving after reset release counts as unexpected.
- Push:
  - Occurs when gnt_CH0_i | gnt_CH1_i.
  - Tag = gnt_CH1_i & ~gnt_CH0_i (0 = CH0, 1 = CH1).
  - Tag written at the write pointer; write pointer increments modulo MAX_OUTSTANDING.
- Pop:
  - Occurs when r_valid_i and count != 0 at cycle start.
  - Head tag is read, read pointer increments modulo MAX_OUTSTANDING.
  - A tag pushed in the same cycle is never popped that cycle (L2 latency >= 1).
- Response output, 1-cycle latency:
  - On the clock edge ending a pop cycle, r_valid_CH[tag]_o <= 1 and the other channel's valid <= 0.
  - r_rdata/r_ID of the selected channel <= r_rdata_i/r_ID_i.
  - The non-selected channel's rdata/ID hold their previous values.
  - Valids are single-cycle pulses; back-to-back pops give back-to-back pulses, possibly alternating channel.
- Count:
  - +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
  - outstanding_o = count.
  - gnt_block_o = (count == MAX_OUTSTANDING), combinational from the registered count.
- Boundary conditions:
  - Full, push with pop same cycle: legal; count stays MAX_OUTSTANDING, no error.
  - Full, push without pop: push dropped, count unchanged, err_o[0] set.
  - Empty, r_valid_i: response dropped, no output valid, err_o[1] set. Any same-cycle push still proceeds.
  - gnt_CH0_i & gnt_CH1_i: single push with tag 0 (CH0), err_o[2] set.
  - Pointer wrap: pointers wrap from MAX_OUTSTANDING-1 to 0; occupancy is tracked by the count, not by pointer comparison.
  - err_o bits are sticky and clear only on reset.

Test Plan:
- Reset then grants CH0, CH1, CH1 on cycles 1–3; responses on cycles 3–5 with rdata 0xA, 0xB, 0xC and ID 1, 2, 3 -> valid pulses CH0 on cycle 4 (0xA, ID 1), CH1 on cycle 5 (0xB, ID 2), CH1 on cycle 6 (0xC, ID 3); outstanding_o returns to 0; err_o = 0.
- MAX_OUTSTANDING=4, four CH0 grants with no responses -> outstanding_o = 4, gnt_block_o = 1. Fifth grant without response -> err_o = 3'b001, outstanding_o stays 4. Then four responses -> four CH0 pulses, gnt_block_o = 0.
- Full FIFO, same-cycle CH1 grant and response -> head tag delivered, count stays 4, err_o = 0. Drain to 0 -> CH1 tag delivered last.
- r_valid_i with empty FIFO, rdata 0xDEAD -> no output valid, err_o[1] = 1. Subsequent normal CH0 transaction still routed correctly.
- gnt_CH0_i = gnt_CH1_i = 1 in one cycle -> outstanding_o +1, err_o[2] = 1. Matching response goes to CH0.
- Ten alternating CH0/CH1 transactions (pointer wrap over 2.5 laps), then assert rst_n low with 2 outstanding; after release, one response -> no valid, err_o = 3'b010.
